// File: rtl/text_pkg.sv
// Shared constants and types for the VGA text-row prefetcher.
// Grid geometry, memory layout and the fetch FSM state encoding.
package text_pkg;

    localparam int CELL_W   = 32;
    localparam int ORIGIN_X = 32;
    localparam int ORIGIN_Y = 32;
    localparam int COLS     = 18;
    localparam int ROWS     = 4;
    localparam int NCHARS   = 61;
    localparam logic [7:0] BASE_ADDR = 8'h0C;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_e;

    function automatic logic [7:0] char_index(
        input logic [7:0] r,
        input logic [7:0] c,
        input int         cols
    );
        return 8'(int'(r) * cols + int'(c));
    endfunction

endpackage

// File: rtl/text_row_prefetch_if.sv
// Data-memory read port shared between the CPU and the row prefetcher.
// The prefetcher side is the master; the CPU/memory side is the slave.
interface text_row_prefetch_if;

    logic        cpu_req;
    logic [7:0]  cpu_addr;
    logic [31:0] mem_rdata;
    logic [7:0]  mem_addr;
    logic        cpu_gnt;

    modport master (
        input  cpu_req,
        input  cpu_addr,
        input  mem_rdata,
        output mem_addr,
        output cpu_gnt
    );

    modport slave (
        output cpu_req,
        output cpu_addr,
        output mem_rdata,
        input  mem_addr,
        input  cpu_gnt
    );

endinterface

// File: rtl/char_line_buffer.sv
// One character row: 8-bit codes with per-entry fill bits.
// Single write port, combinational read port, clear drops all fill bits.
module char_line_buffer #(
    parameter int DEPTH = 18,
    parameter int IW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [7:0]    wdata,
    input  logic [IW-1:0] ridx,
    output logic [7:0]    rdata,
    output logic          rfill
);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [DEPTH-1:0] fill_q;
    logic [DEPTH-1:0] fill_d;

    always_comb begin
        mem_d  = mem_q;
        fill_d = fill_q;
        if (clr) begin
            fill_d = '0;
        end else if (we) begin
            mem_d[widx]  = wdata;
            fill_d[widx] = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        rfill = 1'b0;
        if (int'(ridx) < DEPTH) begin
            rdata = mem_q[ridx];
            rfill = fill_q[ridx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            fill_q <= '0;
        end else begin
            mem_q  <= mem_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/text_row_prefetch.sv
// Prefetches one character row into a line buffer during hblank and
// drives the sprite renderer with the cell code/origin during active video.
module text_row_prefetch #(
    parameter int         COLS      = 18,
    parameter int         ROWS      = 4,
    parameter int         NCHARS    = 61,
    parameter logic [7:0] BASE_ADDR = 8'h0C
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           currentX,
    input  logic [9:0]           currentY,
    text_row_prefetch_if.master  bus,
    output logic [7:0]           char_code,
    output logic [9:0]           initialX,
    output logic [9:0]           initialY,
    output logic                 char_valid,
    output logic                 underrun
);

    import text_pkg::*;

    localparam int LAST_PART = NCHARS - 1 - (ROWS - 1) * COLS;

    fetch_state_e state_q, state_d;
    logic [1:0]   row_q, row_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [4:0]   last_q, last_d;
    logic         cap_vld_q, cap_vld_d;
    logic [4:0]   cap_idx_q, cap_idx_d;
    logic [7:0]   code_q, code_d;
    logic [9:0]   ix_q, ix_d;
    logic [9:0]   iy_q, iy_d;
    logic         vld_q, vld_d;
    logic         unf_q, unf_d;

    logic         trig;
    logic         clr;
    logic [7:0]   fetch_addr;
    logic         in_grid;
    logic [4:0]   col;
    logic [4:0]   rowc;
    logic [7:0]   cell_n;
    logic [7:0]   rd_data;
    logic         rd_fill;
    logic         unused_rdata;

    assign unused_rdata = ^bus.mem_rdata[31:8];

    // Last line before each character row, at the start of hblank.
    assign trig = (currentX == 10'd640)
               && (currentY[4:0] == 5'd31)
               && (currentY < 10'(ROWS * CELL_W));

    assign bus.cpu_gnt  = bus.cpu_req;
    assign bus.mem_addr = bus.cpu_req ? bus.cpu_addr : fetch_addr;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        cap_vld_d  = 1'b0;
        cap_idx_d  = cap_idx_q;
        clr        = 1'b0;
        fetch_addr = '0;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = FETCH;
                    row_d   = currentY[6:5];
                    cnt_d   = '0;
                    last_d  = (currentY[6:5] == 2'(ROWS - 1))
                            ? 5'(LAST_PART) : 5'(COLS - 1);
                    clr     = 1'b1;
                end
            end
            FETCH: begin
                fetch_addr = BASE_ADDR
                           + (char_index(8'(row_q), 8'(cnt_q), COLS) << 2);
                if (!bus.cpu_req) begin
                    cap_vld_d = 1'b1;
                    cap_idx_d = cnt_q;
                    if (cnt_q == last_q) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    char_line_buffer #(
        .DEPTH (COLS),
        .IW    (5)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .we    (cap_vld_q),
        .widx  (cap_idx_q),
        .wdata (bus.mem_rdata[7:0]),
        .ridx  (col),
        .rdata (rd_data),
        .rfill (rd_fill)
    );

    assign in_grid = (currentX >= 10'(ORIGIN_X))
                  && (currentX < 10'(ORIGIN_X + COLS * CELL_W))
                  && (currentY >= 10'(ORIGIN_Y))
                  && (currentY < 10'(ORIGIN_Y + ROWS * CELL_W));
    assign col    = 5'((currentX - 10'(ORIGIN_X)) >> 5);
    assign rowc   = 5'((currentY - 10'(ORIGIN_Y)) >> 5);
    assign cell_n = char_index(8'(rowc), 8'(col), COLS);

    always_comb begin
        code_d = '0;
        vld_d  = 1'b0;
        ix_d   = ix_q;
        iy_d   = iy_q;
        if (in_grid && rd_fill && (int'(cell_n) < NCHARS)) begin
            code_d = rd_data;
            vld_d  = 1'b1;
            ix_d   = {col, 5'b0} + 10'(ORIGIN_X);
            iy_d   = {rowc, 5'b0} + 10'(ORIGIN_Y);
        end
    end

    // Row began drawing while its fetch was still in flight.
    always_comb begin
        unf_d = unf_q;
        if ((state_q != IDLE) && (currentX == 10'd0)
            && (currentY == ((10'(row_q) + 10'd1) << 5))) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            cnt_q     <= '0;
            last_q    <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            code_q    <= '0;
            ix_q      <= '0;
            iy_q      <= '0;
            vld_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
            code_q    <= code_d;
            ix_q      <= ix_d;
            iy_q      <= iy_d;
            vld_q     <= vld_d;
            unf_q     <= unf_d;
        end
    end

    assign char_code  = code_q;
    assign initialX   = ix_q;
    assign initialY   = iy_q;
    assign char_valid = vld_q;
    assign underrun   = unf_q;

endmodule

// File: tb/tb_text_row_prefetch.sv
// Randomized bench for text_row_prefetch with a grid-level reference model.
// Model tracks which cells were fetched and what the memory holds there.
module tb_text_row_prefetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] currentX;
    logic [9:0] currentY;
    logic [7:0] char_code;
    logic [9:0] initialX;
    logic [9:0] initialY;
    logic       char_valid;
    logic       underrun;

    text_row_prefetch_if bus ();

    text_row_prefetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .currentX   (currentX),
        .currentY   (currentY),
        .bus        (bus),
        .char_code  (char_code),
        .initialX   (initialX),
        .initialY   (initialY),
        .char_valid (char_valid),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    logic [31:0] memw [64];

    always @(posedge clk) bus.mem_rdata <= memw[bus.mem_addr[7:2]];

    int         passed = 0;
    int         total  = 0;
    logic [7:0] mbuf [18];
    bit         mfill [18];
    int         mrow;
    int         nexp;
    int         issued;
    logic [9:0] mix;
    logic [9:0] miy;
    logic [7:0] last_addr;

    function automatic logic [7:0] cell_addr(input int n);
        return 8'(12 + 4 * n);
    endfunction

    task automatic clear_model();
        for (int c = 0; c < 18; c++) mfill[c] = 1'b0;
    endtask

    task automatic trigger(input int row);
        @(negedge clk);
        currentX    = 10'd640;
        currentY    = 10'(32 * row + 31);
        bus.cpu_req = 1'b0;
        mrow   = row;
        nexp   = (row == 3) ? 7 : 18;
        issued = 0;
        clear_model();
    endtask

    task automatic run_issue(input int mode, input int stop);
        int         k;
        int         burst;
        bit         req;
        logic [7:0] e;
        k = 0;
        burst = 0;
        while (issued < stop && k < 200) begin
            @(negedge clk);
            currentX = 10'(641 + k);
            req = 1'b0;
            if (mode == 1) req = ($urandom_range(3) == 0);
            if (mode == 2 && issued == 6 && burst < 5) begin
                req = 1'b1;
                burst++;
            end
            bus.cpu_req  = req;
            bus.cpu_addr = 8'($urandom);
            #1;
            total++;
            if (req) begin
                if (bus.cpu_gnt !== 1'b1 || bus.mem_addr !== bus.cpu_addr) begin
                    $display("FAIL cpu_arb: gnt=%0b addr=%h, expected gnt=1 addr=%h",
                             bus.cpu_gnt, bus.mem_addr, bus.cpu_addr);
                end else begin
                    passed++;
                end
            end else begin
                e = cell_addr(18 * mrow + issued);
                if (bus.cpu_gnt !== 1'b0 || bus.mem_addr !== e) begin
                    $display("FAIL fetch_addr[%0d]: gnt=%0b addr=%h, expected gnt=0 addr=%h",
                             issued, bus.cpu_gnt, bus.mem_addr, e);
                end else begin
                    passed++;
                end
                last_addr     = bus.mem_addr;
                mbuf[issued]  = memw[e[7:2]][7:0];
                mfill[issued] = 1'b1;
                issued++;
            end
            k++;
        end
        if (issued < stop) begin
            total++;
            $display("FAIL fetch_timeout: issued %0d, expected %0d", issued, stop);
        end
        if (issued == nexp) begin
            @(negedge clk);
            currentX    = 10'd700;
            bus.cpu_req = 1'b0;
        end
    endtask

    task automatic check_pixel(input int x, input int y, input bit req);
        bit         ev;
        logic [7:0] ec;
        int         c;
        int         r;
        @(negedge clk);
        currentX     = 10'(x);
        currentY     = 10'(y);
        bus.cpu_req  = req;
        bus.cpu_addr = 8'($urandom);
        @(negedge clk);
        ev = 1'b0;
        ec = 8'h00;
        if (x >= 32 && x < 608 && y >= 32 && y < 160) begin
            c = (x - 32) / 32;
            r = (y - 32) / 32;
            if (18 * r + c < 61 && mfill[c]) begin
                ev  = 1'b1;
                ec  = mbuf[c];
                mix = 10'(32 + 32 * c);
                miy = 10'(32 + 32 * r);
            end
        end
        total++;
        if (char_valid !== ev || char_code !== ec
            || initialX !== mix || initialY !== miy) begin
            $display("FAIL pixel(%0d,%0d): got v=%0b code=%h x=%0d y=%0d, expected v=%0b code=%h x=%0d y=%0d",
                     x, y, char_valid, char_code, initialX, initialY, ev, ec, mix, miy);
        end else begin
            passed++;
        end
    endtask

    task automatic check_row(input int r);
        for (int c = 0; c < 18; c++) begin
            check_pixel(32 + 32 * c + int'($urandom_range(31)),
                        32 + 32 * r + int'($urandom_range(31)), 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        currentX     = '0;
        currentY     = '0;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        for (int i = 0; i < 64; i++) memw[i] = $urandom;
        mix = '0;
        miy = '0;
        clear_model();
        #2;
        total++;
        if ({char_code, initialX, initialY, char_valid, underrun} !== 30'd0) begin
            $display("FAIL reset_out: code=%h x=%0d y=%0d v=%0b u=%0b, expected all 0",
                     char_code, initialX, initialY, char_valid, underrun);
        end else begin
            passed++;
        end
        total++;
        if (bus.mem_addr !== 8'h00 || bus.cpu_gnt !== 1'b0) begin
            $display("FAIL reset_port: addr=%h gnt=%0b, expected 00 0",
                     bus.mem_addr, bus.cpu_gnt);
        end else begin
            passed++;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_fetch();
        trigger(0);
        run_issue(0, 18);
        check_pixel(100, 40, 1'b0);
        check_row(0);
        check_pixel(400, 150, 1'b0);
    endtask

    task automatic test_cpu_burst();
        trigger(1);
        run_issue(2, 18);
        check_row(1);
    endtask

    task automatic test_row3();
        trigger(3);
        run_issue(0, 7);
        total++;
        if (last_addr !== 8'hFC) begin
            $display("FAIL row3_last: addr=%h, expected fc", last_addr);
        end else begin
            passed++;
        end
        check_pixel(300, 140, 1'b0);
        check_row(3);
    endtask

    task automatic test_outside();
        check_pixel(10, 10, 1'b0);
        check_pixel(620, 40, 1'b0);
        check_pixel(50, 170, 1'b0);
    endtask

    task automatic test_random();
        trigger(2);
        run_issue(1, 18);
        check_row(2);
        for (int i = 0; i < 30; i++) begin
            check_pixel(int'($urandom_range(639)), int'($urandom_range(199)), 1'b0);
        end
    endtask

    task automatic test_underrun();
        trigger(1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            currentX     = 10'(641 + k);
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = 8'($urandom);
            #1;
            total++;
            if (bus.cpu_gnt !== 1'b1 || bus.mem_addr !== bus.cpu_addr) begin
                $display("FAIL hold_arb: gnt=%0b addr=%h, expected 1 %h",
                         bus.cpu_gnt, bus.mem_addr, bus.cpu_addr);
            end else begin
                passed++;
            end
        end
        total++;
        if (underrun !== 1'b0) begin
            $display("FAIL underrun_early: got %0b, expected 0", underrun);
        end else begin
            passed++;
        end
        @(negedge clk);
        currentX    = 10'd0;
        currentY    = 10'd64;
        bus.cpu_req = 1'b1;
        @(negedge clk);
        currentX = 10'd1;
        total++;
        if (underrun !== 1'b1) begin
            $display("FAIL underrun_set: got %0b, expected 1", underrun);
        end else begin
            passed++;
        end
        check_pixel(40, 64, 1'b1);
        run_issue(0, 18);
        total++;
        if (underrun !== 1'b1) begin
            $display("FAIL underrun_sticky: got %0b, expected 1", underrun);
        end else begin
            passed++;
        end
        check_row(1);
    endtask

    task automatic test_mid_reset();
        trigger(0);
        run_issue(0, 3);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({char_code, initialX, initialY, char_valid, underrun} !== 30'd0
            || bus.mem_addr !== 8'h00) begin
            $display("FAIL async_reset: code=%h x=%0d y=%0d v=%0b u=%0b addr=%h, expected all 0",
                     char_code, initialX, initialY, char_valid, underrun, bus.mem_addr);
        end else begin
            passed++;
        end
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 8'hA5;
        #1;
        total++;
        if (bus.mem_addr !== 8'hA5 || bus.cpu_gnt !== 1'b1) begin
            $display("FAIL reset_cpu_port: addr=%h gnt=%0b, expected a5 1",
                     bus.mem_addr, bus.cpu_gnt);
        end else begin
            passed++;
        end
        bus.cpu_req = 1'b0;
        mix = '0;
        miy = '0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            currentX = 10'(641 + k);
        end
        check_row(0);
        trigger(0);
        run_issue(1, 18);
        check_row(0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_fetch();
        test_cpu_burst();
        test_row3();
        test_outside();
        test_random();
        test_underrun();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/text_row_prefetch.md
# text_row_prefetch

Sequential front end for the VGA text overlay. Before each character row is drawn, it prefetches the row's character words from data memory into an 18-entry line buffer. The fetch runs during horizontal blanking and shares the single data-memory read port with the CPU, which always has priority. During active video it outputs, one cycle after each pixel position, the character code and the cell origin to the sprite renderer.

## Interface
Parameters:
- COLS, 18, character cells per row
- ROWS, 4, character rows
- NCHARS, 61, total displayable characters (last row partial)
- BASE_ADDR, 8'h0C, byte address of character 0 (one word per character, stride 4)

Ports:
- clk  in  1  pixel clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- currentX  in  10  pixel column from VGA timing generator
- currentY  in  10  pixel line from VGA timing generator
- cpu_req  in  1  CPU requests the data-memory port this cycle
- cpu_addr  in  8  CPU byte address
- mem_rdata  in  32  data-memory read data, valid one cycle after mem_addr
- mem_addr  out  8  data-memory address (muxed)
- cpu_gnt  out  1  CPU owns the port this cycle
- char_code  out  8  character for the current cell
- initialX  out  10  cell origin X
- initialY  out  10  cell origin Y
- char_valid  out  1  current pixel is inside a filled cell
- underrun  out  1  sticky: a row started before its fetch completed

## Operation
- Grid: 32x32-pixel cells with origin (32,32). Cell (r,c) covers X in [32+32c, 64+32c) and Y in [32+32r, 64+32r). Its character is index n = 18r + c, at word address BASE_ADDR + 4n, taken from byte mem_rdata[7:0].
- Cells with n ≥ 61 (row 3, columns 7–17) are blank.
- Arbitration is combinational:
  - cpu_gnt = cpu_req.
  - mem_addr = cpu_req ? cpu_addr : fetch address.
  - A fetch issue happens only in a cycle where cpu_req = 0 and the FSM is in FETCH.
- FSM states:
  - IDLE → FETCH when currentX == 640 and currentY ∈ {31, 63, 95, 127}. Row r = currentY[6:5]. On entry, all 18 fill bits are cleared, issue_cnt = 0, and last = (r == 3) ? 6 : 17.
  - FETCH: each non-CPU cycle issues BASE_ADDR + 4(18r + issue_cnt), then issue_cnt increments. After issuing index last, go to DRAIN.
  - DRAIN: one cycle for the final capture, then go to IDLE.
- Capture pipeline: a registered (valid, index) pair follows every issue. In the next cycle, mem_rdata[7:0] is written to buf[index] and fill[index] is set.
- Display path, registered each cycle:
  - Pixel inside the grid at column c with fill[c] = 1 and n < 61: char_code = buf[c], initialX/initialY = cell origin, char_valid = 1.
  - Otherwise: char_code = 0, char_valid = 0, and initialX/initialY hold their last values.
- Underrun: if currentX == 0 and currentY equals the row's first line (32(r+1)) while the FSM is in FETCH or DRAIN, underrun is set. The fetch continues; cells that are not yet filled show char_valid = 0.
- A trigger that arrives while not in IDLE is ignored.

## Timing
- Reset (asynchronous): FSM = IDLE, buf and fill = 0, char_code = 0, initialX = 0, initialY = 0, char_valid = 0, underrun = 0, capture valid = 0. mem_addr and cpu_gnt follow cpu_req/cpu_addr combinationally.
- Reset deassertion mid-row leaves the buffer empty until the next trigger.
- Display latency is 1 cycle from currentX/currentY to the outputs.
- Fetch duration with no CPU traffic:
  - Full row: 18 issue cycles + 1 DRAIN cycle, done by X = 659.
  - Row 3: 7 issue cycles + 1 DRAIN cycle.
- Every cycle with cpu_req high adds one cycle to the fetch.
- Simultaneous cpu_req and a fetch issue: the CPU wins and the fetch index does not advance.
- The capture of a previously issued read still completes, because mem_rdata belongs to the prior cycle's address. Capture happens only for cycles where the fetch, not the CPU, issued the address.

## Structure
- Shared package text_pkg: CELL_W = 32, ORIGIN_X = 32, ORIGIN_Y = 32, COLS, ROWS, NCHARS, BASE_ADDR, and a typedef for the fetch state enum (IDLE, FETCH, DRAIN).
- One sub-module, char_line_buffer: an 18x8 register array with per-entry fill bits, one write port, one combinational read port, and a clear input.

## Test plan
- Idle port, trigger at (640,31): addresses 0x0C…0x50 issued on consecutive cycles; a pixel at (100,40) yields char_code = mem[0x14][7:0], initialX = 96, initialY = 32, char_valid = 1 one cycle later.
- cpu_req held high for 5 cycles mid-fetch: cpu_gnt = 1 and mem_addr = cpu_addr for those cycles; fetch resumes at the next index; all 18 entries are correct.
- Row 3 trigger at (640,127): 7 issues, last address 0xFC; pixel (300,140) → char_valid = 0.
- cpu_req held high from X = 640 through the next line's X = 0 at Y = 64: underrun = 1 and stays 1; cells not yet filled show char_valid = 0.
- rst_n asserted mid-fetch: all outputs are 0 immediately (asynchronously); after release, no fetch occurs until the next trigger.
- Pixels outside the grid, e.g. (10,10) and (620,40): char_valid = 0, char_code = 0.
